// File: rtl/transformer_layer_ctrl.sv
// ----------------------------------------------------------------------------
// transformer_layer_ctrl
//
// Per-layer stage sequencer for one transformer encoder layer. A single
// layer_start request walks the seven layer engines in fixed order
// (LN1, QKV, ATTN x NUM_HEAD, PROJ, LN2, FC1, FC2). Each engine gets a
// one-cycle start pulse, and the sequencer waits for that engine's done
// pulse before it issues the next start. FC2 completion produces a
// one-cycle layer_done, which feeds back to the model-level controller.
//
// Optional feature:
//   LAYER_CTRL_WDT_EN  - per-stage watchdog. When it is defined, a stage that
//                        stays silent for TIMEOUT_CYC cycles aborts the layer.
//                        The abort sets the sticky error flag and records the
//                        stage in err_stage. When it is undefined, there is no
//                        counter, error/err_stage read 0, and WAIT holds
//                        indefinitely.
//
// Parameters:
//   NUM_HEAD     attention-head passes per layer (>= 1)
//   TIMEOUT_CYC  watchdog limit in cycles per stage (watchdog builds only)
//
// Ports:
//   clk          rising-edge clock
//   rstn         asynchronous active-low reset
//   layer_start  one-cycle request to run a layer; ignored while busy
//   stage_done   per-stage done pulses (0=LN1 1=QKV 2=ATTN 3=PROJ 4=LN2
//                5=FC1 6=FC2)
//   stage_start  one-hot start pulses, same indexing as stage_done
//   head_idx     current attention head, valid while stage 2 is active
//   busy         high while a layer is in progress
//   layer_done   one-cycle pulse when FC2 completes
//   error        sticky watchdog flag, cleared by the next accepted start
//   err_stage    index of the stage that timed out
// ----------------------------------------------------------------------------
module transformer_layer_ctrl #(
   parameter int  NUM_HEAD    = 12,
   parameter int  TIMEOUT_CYC = 65535,
   localparam int HEAD_W      = (NUM_HEAD > 1) ? $clog2(NUM_HEAD) : 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              layer_start,
   input  logic [6:0]        stage_done,
   output logic [6:0]        stage_start,
   output logic [HEAD_W-1:0] head_idx,
   output logic              busy,
   output logic              layer_done,
   output logic              error,
   output logic [2:0]        err_stage
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   localparam logic [2:0]        STG_LN1   = 3'd0;
   localparam logic [2:0]        STG_ATTN  = 3'd2;
   localparam logic [2:0]        STG_FC2   = 3'd6;
   localparam logic [HEAD_W-1:0] HEAD_LAST = HEAD_W'(NUM_HEAD - 1);

   state_t     state;
   logic [2:0] cur;    // stage whose done pulse is being awaited

   function automatic logic [6:0] onehot(input logic [2:0] s);
      return 7'b000_0001 << s;
   endfunction

`ifdef LAYER_CTRL_WDT_EN
   localparam int               CNT_W    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYC);

   // Counter reads 0 in the cycle of a start pulse and k in the k-th cycle
   // after it. The abort happens only at an edge where it already holds
   // TIMEOUT_CYC and the awaited done is absent, so a done on that edge wins.
   logic [CNT_W-1:0] wdt_cnt;
   logic             timeout;

   assign timeout = (wdt_cnt == CNT_TERM);
`else
   assign error     = 1'b0;
   assign err_stage = 3'd0;
`endif

   // NOTE: every register here, pulse outputs included, sits in one clocked
   // block with non-blocking assignments. Each output is therefore a flop,
   // and the decisions below all see the pre-edge values of cur and head_idx.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         // NOTE: the reset is asynchronous, so a mid-layer reset drops every
         // output to 0 at once without waiting for a clock edge.
         state       <= ST_IDLE;
         cur         <= STG_LN1;
         head_idx    <= '0;
         stage_start <= '0;
         busy        <= 1'b0;
         layer_done  <= 1'b0;
`ifdef LAYER_CTRL_WDT_EN
         error       <= 1'b0;
         err_stage   <= 3'd0;
         wdt_cnt     <= '0;
`endif
      end else begin
         // NOTE: pulse outputs default low every cycle. The branches below
         // raise them only for the one cycle that follows an event.
         stage_start <= '0;
         layer_done  <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (layer_start) begin
                  state       <= ST_WAIT;
                  busy        <= 1'b1;
                  cur         <= STG_LN1;
                  head_idx    <= '0;
                  stage_start <= onehot(STG_LN1);
`ifdef LAYER_CTRL_WDT_EN
                  error       <= 1'b0;
                  err_stage   <= 3'd0;
                  wdt_cnt     <= '0;
`endif
               end
            end

            ST_WAIT: begin
               // Only the awaited stage's done bit is looked at. Stray done
               // bits and layer_start are dropped here.
               if (stage_done[cur]) begin
`ifdef LAYER_CTRL_WDT_EN
                  wdt_cnt <= '0;
`endif
                  if (cur == STG_FC2) begin
                     state      <= ST_IDLE;
                     busy       <= 1'b0;
                     cur        <= STG_LN1;
                     layer_done <= 1'b1;
                  end else if ((cur == STG_ATTN) && (head_idx != HEAD_LAST)) begin
                     // Another head pass: re-issue the attention engine.
                     head_idx    <= head_idx + HEAD_W'(1);
                     stage_start <= onehot(STG_ATTN);
                  end else begin
                     if (cur == STG_ATTN) begin
                        head_idx <= '0;
                     end
                     cur         <= cur + 3'd1;
                     stage_start <= onehot(cur + 3'd1);
                  end
               end
`ifdef LAYER_CTRL_WDT_EN
               else if (timeout) begin
                  // Abort without layer_done. The layer controller above sees
                  // busy drop and reads error/err_stage.
                  state     <= ST_IDLE;
                  busy      <= 1'b0;
                  cur       <= STG_LN1;
                  head_idx  <= '0;
                  error     <= 1'b1;
                  err_stage <= cur;
                  wdt_cnt   <= '0;
               end else begin
                  wdt_cnt <= wdt_cnt + CNT_W'(1);
               end
`endif
            end

            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_transformer_layer_ctrl.sv
// ----------------------------------------------------------------------------
// tb_transformer_layer_ctrl
//
// Self-checking bench for transformer_layer_ctrl with NUM_HEAD=3 and
// TIMEOUT_CYC=20. The reference model is a list of the stages the layer
// issues (LN1, QKV, ATTN x3, PROJ, LN2, FC1, FC2) plus a position in that
// list. Engine responders return done a chosen number of cycles after each
// start pulse. Watchdog scenarios are compiled only when LAYER_CTRL_WDT_EN
// is defined.
// ----------------------------------------------------------------------------
module tb_transformer_layer_ctrl;

   localparam int NH = 3;
   localparam int TO = 20;
   localparam int HW = 2;

   logic          clk = 1'b0;
   logic          rstn;
   logic          layer_start;
   logic [6:0]    stage_done;
   logic [6:0]    stage_start;
   logic [HW-1:0] head_idx;
   logic          busy;
   logic          layer_done;
   logic          error;
   logic [2:0]    err_stage;

   transformer_layer_ctrl #(.NUM_HEAD(NH), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rstn(rstn), .layer_start(layer_start), .stage_done(stage_done),
      .stage_start(stage_start), .head_idx(head_idx), .busy(busy),
      .layer_done(layer_done), .error(error), .err_stage(err_stage)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   int         seq[$];   // stage issue order for one layer
   bit         m_busy;
   int         m_pos;    // index into seq of the stage being awaited
   int         m_wait;   // cycles elapsed since that stage's start pulse
   logic [6:0] e_start;
   logic       e_busy, e_done, e_err;
   logic [2:0] e_errst;
   int         e_head;

   task automatic model_reset();
      m_busy = 0; m_pos = 0; m_wait = 0;
      e_start = '0; e_busy = 0; e_done = 0; e_err = 0; e_errst = '0; e_head = 0;
   endtask

   // Predicts the outputs for the next cycle from the inputs sampled at the coming edge.
   task automatic predict(input logic ls, input logic [6:0] sd);
      e_start = '0;
      e_done  = 0;
      if (!m_busy) begin
         if (ls) begin
            m_busy = 1; m_pos = 0; m_wait = 0;
            e_start = 7'(1 << seq[0]);
            e_err = 0; e_errst = '0;
         end
      end else if (sd[seq[m_pos]]) begin
         m_wait = 0;
         if (m_pos == seq.size() - 1) begin
            m_busy = 0; e_done = 1;
         end else begin
            m_pos++;
            e_start = 7'(1 << seq[m_pos]);
         end
      end
`ifdef LAYER_CTRL_WDT_EN
      else if (m_wait == TO) begin
         m_busy = 0; e_err = 1; e_errst = 3'(seq[m_pos]);
      end
`endif
      else begin
         m_wait++;
      end
      e_busy = m_busy;
      // Heads are numbered by position among the consecutive ATTN entries.
      e_head = (m_busy && seq[m_pos] == 2) ? m_pos - 2 : 0;
   endtask

   // ---------------- engine responders and logs ----------------
   int dly[7];          // per-stage done delay, 0 = random 1..6
   int hold_stage = -1; // stage whose done is withheld
   int pend_stage = -1;
   int pend_at    = 0;
   int n_ldone    = 0;
   int ldone_cyc  = 0;
   int starts_q[$];
   int start_cyc_q[$];
   int head_q[$];

   function automatic logic [6:0] noise(input bit en);
      return en ? 7'($urandom & $urandom & $urandom) : 7'd0;
   endfunction

   // One cycle: check the current outputs, answer start pulses, drive the
   // inputs for the coming edge, advance the model.
   task automatic tick(input logic ls, input logic [6:0] extra);
      logic [6:0] sd;
      check("stage_start", 32'(stage_start), 32'(e_start));
      check("busy", 32'(busy), 32'(e_busy));
      check("layer_done", 32'(layer_done), 32'(e_done));
      check("head_idx", 32'(head_idx), 32'(e_head));
      check("error", 32'(error), 32'(e_err));
      check("err_stage", 32'(err_stage), 32'(e_errst));
      if (layer_done) begin
         n_ldone++;
         ldone_cyc = cyc;
      end
      if (stage_start != '0) begin
         pend_stage = $clog2(stage_start);
         starts_q.push_back(pend_stage);
         start_cyc_q.push_back(cyc);
         head_q.push_back(int'(head_idx));
         pend_at = cyc + ((dly[pend_stage] != 0) ? dly[pend_stage] : int'($urandom_range(1, 6)));
         if (pend_stage == hold_stage) pend_stage = -1;
      end
      sd = extra;
      if (m_busy) sd[seq[m_pos]] = 1'b0;  // stray bits only on stages not awaited
      if (pend_stage >= 0 && pend_at == cyc) begin
         sd[pend_stage] = 1'b1;
         pend_stage = -1;
      end
      layer_start = ls;
      stage_done  = sd;
      predict(ls, sd);
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_until_idle(input int budget, input bit rnd);
      int n = 0;
      while (m_busy && n < budget) begin
         tick(rnd ? ($urandom_range(0, 3) == 0) : 1'b0, noise(rnd));
         n++;
      end
      check("layer_within_budget", 32'(n < budget), 32'd1);
   endtask

   task automatic set_dly(input int d);
      foreach (dly[i]) dly[i] = d;
   endtask

   task automatic clear_logs();
      starts_q.delete(); start_cyc_q.delete(); head_q.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      int exp_order[9];
      int base;
      int n;

      seq.delete();
      seq.push_back(0); seq.push_back(1);
      for (int h = 0; h < NH; h++) seq.push_back(2);
      for (int s = 3; s <= 6; s++) seq.push_back(s);
      exp_order = '{0, 1, 2, 2, 2, 3, 4, 5, 6};

      // ---- reset ----
      rstn = 1'b0; layer_start = 1'b0; stage_done = '0;
      model_reset();
      set_dly(0);
      repeat (2) @(negedge clk);
      check("rst_stage_start", 32'(stage_start), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_layer_done", 32'(layer_done), 32'd0);
      check("rst_head_idx", 32'(head_idx), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_err_stage", 32'(err_stage), 32'd0);
      rstn = 1'b1;
      tick(0, '0);

      // ---- directed layer, engines answer 4 cycles after start ----
      set_dly(4);
      clear_logs();
      tick(1, '0);
      run_until_idle(200, 0);
      tick(0, '0);   // the layer_done cycle
      check("t1_num_starts", 32'(starts_q.size()), 32'd9);
      for (int i = 0; i < 9; i++) begin
         if (i < starts_q.size()) begin
            check("t1_order", 32'(starts_q[i]), 32'(exp_order[i]));
            if (i > 0) check("t1_gap", 32'(start_cyc_q[i] - start_cyc_q[i-1]), 32'd5);
            if (i >= 2 && i <= 4) check("t1_head", 32'(head_q[i]), 32'(i - 2));
         end
      end
      if (start_cyc_q.size() > 0)
         check("t1_done_gap", 32'(ldone_cyc - start_cyc_q[start_cyc_q.size()-1]), 32'd5);

      // ---- 12 back-to-back layers, start on the layer_done cycle ----
      set_dly(0);
      base = n_ldone;
      for (int l = 0; l < 12; l++) begin
         tick(1, noise(1));
         run_until_idle(300, 1);
      end
      tick(0, '0);
      check("b2b_layer_done_count", 32'(n_ldone - base), 32'd12);

      // ---- stray stage_done[5] at QKV and layer_start while busy ----
      set_dly(0);
      dly[1] = 8;
      clear_logs();
      tick(1, '0);
      n = 0;
      while (!(m_busy && m_pos == 1) && n < 20) begin tick(0, '0); n++; end
      tick(1, 7'b010_0000);
      tick(1, 7'b010_0000);
      check("stray_no_extra_start", 32'(starts_q.size()), 32'd2);
      run_until_idle(300, 0);
      tick(0, '0);

      // ---- reset during ATTN head 1 ----
      set_dly(0);
      tick(1, '0);
      n = 0;
      while (!(m_busy && m_pos == 3) && n < 100) begin tick(0, '0); n++; end
      check("reached_attn_head1", 32'(head_idx), 32'd1);
      #2 rstn = 1'b0;
      layer_start = 1'b0; stage_done = '0;
      #1;
      check("arst_stage_start", 32'(stage_start), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_head_idx", 32'(head_idx), 32'd0);
      check("arst_layer_done", 32'(layer_done), 32'd0);
      model_reset();
      pend_stage = -1;
      @(negedge clk);
      cyc++;
      rstn = 1'b1;
      tick(0, '0);
      tick(1, '0);
      check("restart_at_ln1", 32'(stage_start), 32'd1);
      run_until_idle(300, 0);
      tick(0, '0);

`ifdef LAYER_CTRL_WDT_EN
      // ---- watchdog: FC1 never answers ----
      set_dly(0);
      hold_stage = 5;
      base = n_ldone;
      tick(1, '0);
      run_until_idle(300, 0);
      check("wdt_error", 32'(error), 32'd1);
      check("wdt_err_stage", 32'(err_stage), 32'd5);
      check("wdt_busy", 32'(busy), 32'd0);
      tick(0, '0);
      check("wdt_no_layer_done", 32'(n_ldone - base), 32'd0);
      hold_stage = -1;
      tick(1, '0);
      check("wdt_error_cleared", 32'(error), 32'd0);
      run_until_idle(300, 0);
      tick(0, '0);

      // ---- QKV done on the terminal count: the layer proceeds ----
      set_dly(0);
      dly[1] = TO;
      base = n_ldone;
      tick(1, '0);
      run_until_idle(300, 0);
      tick(0, '0);
      check("term_done_no_error", 32'(error), 32'd0);
      check("term_done_layer_done", 32'(n_ldone - base), 32'd1);

      // ---- QKV done one cycle past the terminal count: timeout ----
      dly[1] = TO + 1;
      tick(1, '0);
      run_until_idle(300, 0);
      check("late_done_error", 32'(error), 32'd1);
      check("late_done_err_stage", 32'(err_stage), 32'd1);
      pend_stage = -1;
      tick(0, '0);
`endif

      // ---- randomized layers with stray inputs and idle gaps ----
      set_dly(0);
      for (int l = 0; l < 20; l++) begin
         n = $urandom_range(0, 3);
         for (int g = 0; g < n; g++) tick(0, noise(1));
         tick(1, noise(1));
         run_until_idle(300, 1);
      end
      tick(0, '0);
      check("final_idle_busy", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/transformer_layer_ctrl.md
# transformer_layer_ctrl

Per-layer stage sequencer for one transformer encoder layer. It sits under the model-level controller. The layer-start pulse from that controller drives `layer_start`, and `layer_done` feeds back as that controller's linear2-done input. The block issues one-cycle start pulses to the seven layer datapath engines in fixed order and waits for each engine's done pulse before moving on. The attention engine is issued once per head.

## Interface
Parameters:
- `NUM_HEAD`, default 12: number of attention-head passes per layer. Must be ≥ 1.
- `TIMEOUT_CYC`, default 65535: watchdog limit in cycles per stage. Used only with `LAYER_CTRL_WDT_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `layer_start` in 1: one-cycle request to run one layer. Ignored while `busy`.
- `stage_done` in 7: per-stage done pulses. Index 0 = LN1, 1 = QKV, 2 = ATTN, 3 = PROJ, 4 = LN2, 5 = FC1, 6 = FC2.
- `stage_start` out 7: one-hot, one-cycle start pulses, same indexing as `stage_done`.
- `head_idx` out max(1,$clog2(NUM_HEAD)): current attention head. Valid while stage 2 is active.
- `busy` out 1: high while a layer is in progress.
- `layer_done` out 1: one-cycle pulse when FC2 completes.
- `error` out 1: sticky watchdog flag. Cleared by the next accepted `layer_start`.
- `err_stage` out 3: index of the stage that timed out.

## Operation
- States: IDLE and WAIT.
  - A 3-bit register `cur` holds the active stage.
  - A head counter holds the current attention head.
- IDLE:
  - `cur`=0, `head_idx`=0.
  - On `layer_start`:
    - go to WAIT;
    - pulse `stage_start[0]`;
    - clear `error` and `err_stage`.
- WAIT: only `stage_done[cur]` is honoured. Done bits of other stages are ignored and change no state.
  - `cur`≠2, `cur`≠6: on done, `cur`←`cur`+1 and pulse `stage_start[cur+1]`.
  - `cur`=2 and `head_idx`<`NUM_HEAD`-1: `head_idx`+1, re-pulse `stage_start[2]`.
  - `cur`=2 and `head_idx`=`NUM_HEAD`-1: `head_idx`←0, `cur`←3, pulse `stage_start[3]`.
  - `cur`=6: go to IDLE and pulse `layer_done`.
- At most one `stage_start` bit is high in any cycle. `stage_start` is never high in IDLE except on the entry pulse.
- `busy` = (state==WAIT).
- `layer_start` while `busy` is dropped silently. It is not queued.
- Reset mid-layer: all state returns to IDLE immediately and asynchronously. Engines are not notified; they are reset by the same `rstn`.

## Timing
- Reset values: `stage_start`=0, `head_idx`=0, `busy`=0, `layer_done`=0, `error`=0, `err_stage`=0. State is IDLE.
- All outputs are registered.
- `layer_start` sampled at edge t gives `stage_start[0]` and `busy` high in cycle t+1.
- `stage_done[s]` sampled at edge t gives the next start pulse in cycle t+1. Per-stage overhead is 1 cycle.
- FC2 done at edge t gives `layer_done`=1 and `busy`=0 in cycle t+1. A `layer_start` in that same cycle is accepted, so layers run back-to-back with no gap cycle.
- A done arriving in the same cycle as its own start pulse is not possible by construction. Engines must assert done no earlier than the cycle after start.
- Minimum layer latency with 1-cycle engines: 7+`NUM_HEAD`-1 stage issues, each 2 cycles apart.

## Configuration
- `LAYER_CTRL_WDT_EN` defined:
  - A stage-cycle counter of width $clog2(TIMEOUT_CYC+1) clears on each start pulse and increments in WAIT.
  - If it reaches `TIMEOUT_CYC` without `stage_done[cur]`:
    - state goes to IDLE, `busy`=0;
    - `error`←1 and `err_stage`←`cur`;
    - no `layer_done` is issued.
  - A done arriving in the same cycle as the terminal count wins; no error is raised.
- `LAYER_CTRL_WDT_EN` undefined:
  - no counter;
  - `error` and `err_stage` are tied to 0;
  - WAIT holds indefinitely.

## Test plan
- Reset, then `layer_start`, with `NUM_HEAD`=3 and every engine returning done 4 cycles after its start. Expect:
  - start pulses in order 0,1,2,2,2,3,4,5,6, each exactly 5 cycles apart;
  - `head_idx` reading 0,1,2 during the attention pulses;
  - one `layer_done` 5 cycles after the last start.
- `layer_start` asserted on the `layer_done` cycle, repeated for 12 layers. Expect no gap cycles and 12 `layer_done` pulses.
- Spurious `stage_done[5]` while `cur`=1, plus `layer_start` while `busy`. Expect no state change and no extra pulses.
- `rstn` low while `cur`=2 and `head_idx`=1. Expect all outputs 0 immediately; the next `layer_start` restarts at stage 0.
- With `LAYER_CTRL_WDT_EN` and `TIMEOUT_CYC`=20, hold off the FC1 done. Expect:
  - `error`=1, `err_stage`=5, `busy`=0;
  - no `layer_done`;
  - the next `layer_start` clears `error`.
- With `LAYER_CTRL_WDT_EN` and `TIMEOUT_CYC`=20, assert the QKV done exactly on the terminal count. Expect the layer to proceed and `error` to stay 0.
